// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus master: access-size encodings,
// the transfer FSM state type and the alignment rule used to reject
// accesses before any bus cycle is issued.
package mem_bus_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_GAP  = 2'b10
  } state_t;

  // Size 11 is not a legal encoding, so it is treated as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] lo);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = lo[0];
      SIZE_WORD: is_misaligned = (lo != 2'b00);
      default:   is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_master_if.sv
// Avalon-MM port bundle between the bus master and the RAM slave.
//   address/byteenable/read/write/writedata : master -> slave
//   waitrequest/readdata                    : slave  -> master
interface mem_bus_master_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic              waitrequest;
  logic [31:0]       readdata;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mem_bus_master_lane_align.sv
// Combinational lane handling for sub-word accesses (little-endian).
//   size, lo, wdata    -> byteenable, writedata (store-side replication)
//   size, lo, sgn,
//   readdata           -> rdata (shifted, truncated, sign/zero extended)
import mem_bus_pkg::*;

module mem_lane_align (
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] readdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] rdata
);
  logic [31:0] shifted;

  always_comb begin
    byteenable = 4'b1111;
    writedata  = wdata;
    rdata      = '0;
    shifted    = readdata >> {lo, 3'b000};
    case (size)
      SIZE_BYTE: begin
        byteenable = 4'b0001 << lo;
        writedata  = {4{wdata[7:0]}};
        rdata      = {{24{sgn & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        byteenable = lo[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{wdata[15:0]}};
        rdata      = {{16{sgn & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        rdata = shifted;
      end
    endcase
  end
endmodule

// File: rtl/mem_bus_master.sv
// Avalon-MM master serving instruction fetch and data load/store over one
// shared port. Data requests have fixed priority. Every transfer runs
// IDLE -> BUS -> GAP; the GAP cycle drops the strobes and carries the
// one-cycle done pulse of the served client. All outputs are registered.
//   clk, reset          : clock, synchronous active-high reset
//   ifetch_*            : fetch client (req level, done pulse, data)
//   dmem_*              : data client (req level, done pulse, rdata, misaligned)
//   bus                 : Avalon-MM master modport
import mem_bus_pkg::*;

module mem_bus_master #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifetch_req,
  input  logic [ADDR_W-1:0] ifetch_addr,
  output logic              ifetch_done,
  output logic [31:0]       ifetch_data,
  input  logic              dmem_req,
  input  logic              dmem_we,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [1:0]        dmem_size,
  input  logic              dmem_signed,
  input  logic [31:0]       dmem_wdata,
  output logic              dmem_done,
  output logic [31:0]       dmem_rdata,
  output logic              dmem_misaligned,
  mem_bus_master_if.master  bus
);
  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t            state_q, state_d;
  logic              serve_dmem_q, serve_dmem_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        lo_q, lo_d;
  logic              sgn_q, sgn_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       writedata_q, writedata_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              ifetch_done_q, ifetch_done_d;
  logic [31:0]       ifetch_data_q, ifetch_data_d;
  logic              dmem_done_q, dmem_done_d;
  logic [31:0]       dmem_rdata_q, dmem_rdata_d;
  logic              dmem_mis_q, dmem_mis_d;

  // The aligner sees the live request in IDLE (lane/data generation) and the
  // latched access in BUS (read extraction).
  logic [1:0]  al_size, al_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;

  assign al_size = (state_q == ST_IDLE) ? dmem_size      : size_q;
  assign al_lo   = (state_q == ST_IDLE) ? dmem_addr[1:0] : lo_q;

  mem_lane_align u_align (
    .size       (al_size),
    .lo         (al_lo),
    .sgn        (sgn_q),
    .wdata      (dmem_wdata),
    .readdata   (bus.readdata),
    .byteenable (al_be),
    .writedata  (al_wdata),
    .rdata      (al_rdata)
  );

  always_comb begin
    state_d       = state_q;
    serve_dmem_d  = serve_dmem_q;
    we_d          = we_q;
    size_d        = size_q;
    lo_d          = lo_q;
    sgn_d         = sgn_q;
    address_d     = address_q;
    be_d          = be_q;
    writedata_d   = writedata_q;
    read_d        = read_q;
    write_d       = write_q;
    ifetch_done_d = 1'b0;
    ifetch_data_d = ifetch_data_q;
    dmem_done_d   = 1'b0;
    dmem_rdata_d  = dmem_rdata_q;
    dmem_mis_d    = dmem_mis_q;
    case (state_q)
      ST_IDLE: begin
        if (dmem_req) begin
          if (is_misaligned(dmem_size, dmem_addr[1:0])) begin
            // Rejected without touching the bus; done comes out of GAP.
            state_d      = ST_GAP;
            dmem_done_d  = 1'b1;
            dmem_mis_d   = 1'b1;
            dmem_rdata_d = '0;
          end else begin
            state_d      = ST_BUS;
            serve_dmem_d = 1'b1;
            we_d         = dmem_we;
            size_d       = dmem_size;
            lo_d         = dmem_addr[1:0];
            sgn_d        = dmem_signed;
            address_d    = dmem_addr & WORD_MASK;
            be_d         = al_be;
            writedata_d  = al_wdata;
            read_d       = ~dmem_we;
            write_d      = dmem_we;
          end
        end else if (ifetch_req) begin
          state_d      = ST_BUS;
          serve_dmem_d = 1'b0;
          address_d    = ifetch_addr & WORD_MASK;
          be_d         = 4'b1111;
          read_d       = 1'b1;
          write_d      = 1'b0;
        end
      end
      ST_BUS: begin
        if (!bus.waitrequest) begin
          state_d = ST_GAP;
          read_d  = 1'b0;
          write_d = 1'b0;
          if (serve_dmem_q) begin
            dmem_done_d  = 1'b1;
            dmem_mis_d   = 1'b0;
            dmem_rdata_d = we_q ? 32'd0 : al_rdata;
          end else begin
            ifetch_done_d = 1'b1;
            ifetch_data_d = bus.readdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      serve_dmem_q  <= 1'b0;
      we_q          <= 1'b0;
      size_q        <= '0;
      lo_q          <= '0;
      sgn_q         <= 1'b0;
      address_q     <= '0;
      be_q          <= '0;
      writedata_q   <= '0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      ifetch_done_q <= 1'b0;
      ifetch_data_q <= '0;
      dmem_done_q   <= 1'b0;
      dmem_rdata_q  <= '0;
      dmem_mis_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      serve_dmem_q  <= serve_dmem_d;
      we_q          <= we_d;
      size_q        <= size_d;
      lo_q          <= lo_d;
      sgn_q         <= sgn_d;
      address_q     <= address_d;
      be_q          <= be_d;
      writedata_q   <= writedata_d;
      read_q        <= read_d;
      write_q       <= write_d;
      ifetch_done_q <= ifetch_done_d;
      ifetch_data_q <= ifetch_data_d;
      dmem_done_q   <= dmem_done_d;
      dmem_rdata_q  <= dmem_rdata_d;
      dmem_mis_q    <= dmem_mis_d;
    end
  end

  assign bus.address      = address_q;
  assign bus.byteenable   = be_q;
  assign bus.read         = read_q;
  assign bus.write        = write_q;
  assign bus.writedata    = writedata_q;
  assign ifetch_done      = ifetch_done_q;
  assign ifetch_data      = ifetch_data_q;
  assign dmem_done        = dmem_done_q;
  assign dmem_rdata       = dmem_rdata_q;
  assign dmem_misaligned  = dmem_mis_q;
endmodule
